// File: rtl/cascade_controller_pkg.sv
// Shared types and constants for the Haar cascade controller.
// Stage indices below NUM_FIRST_STAGES come from embedded memory.
package cascade_pkg;

    localparam int NUM_STAGES       = 25;
    localparam int NUM_FIRST_STAGES = 3;
    localparam int CNT_W            = 12;
    localparam int PASSED_W         = 5;

    localparam logic [NUM_STAGES-1:0] TRACK_MASK =
        NUM_STAGES'(((1 << NUM_STAGES) - 1) &
                    ~((1 << NUM_FIRST_STAGES) - 1));

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_FIRST,
        ST_LATER,
        ST_RESULT,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/cascade_controller_if.sv
// Bus between the cascade controller and scanner / database / evaluators.
// master is the controller side, slave the surrounding blocks.
interface cascade_controller_if;
    import cascade_pkg::*;

    logic                  i_load_done;
    logic                  i_window_valid;
    logic                  o_window_ready;
    logic                  i_first_stage_done;
    logic                  i_first_stage_pass;
    logic [NUM_STAGES-1:0] i_end_database;
    logic [NUM_STAGES-1:0] i_stage_fail;
    logic                  o_enable;
    logic                  o_pass_first_stage;
    logic                  o_reset_database;
    logic                  o_result_valid;
    logic                  o_is_face;
    logic                  o_timeout;
    logic [PASSED_W-1:0]   o_stages_passed;
    logic                  o_busy;

    modport master (
        input  i_load_done,
        input  i_window_valid,
        output o_window_ready,
        input  i_first_stage_done,
        input  i_first_stage_pass,
        input  i_end_database,
        input  i_stage_fail,
        output o_enable,
        output o_pass_first_stage,
        output o_reset_database,
        output o_result_valid,
        output o_is_face,
        output o_timeout,
        output o_stages_passed,
        output o_busy
    );

    modport slave (
        output i_load_done,
        output i_window_valid,
        input  o_window_ready,
        output i_first_stage_done,
        output i_first_stage_pass,
        output i_end_database,
        output i_stage_fail,
        input  o_enable,
        input  o_pass_first_stage,
        input  o_reset_database,
        input  o_result_valid,
        input  o_is_face,
        input  o_timeout,
        input  o_stages_passed,
        input  o_busy
    );

endinterface

// File: rtl/cascade_controller_popcount.sv
// Combinational population count of a W-bit vector.
module popcount #(
    parameter int W = 8,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/cascade_controller.sv
// Sequences one window through the cascade: first stage, later stages,
// verdict, then a database flush before the next window.
module cascade_controller
    import cascade_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int FLUSH_CYCLES   = 2
) (
    input logic         clk,
    input logic         reset,
    cascade_controller_if.master bus
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int PW = $clog2(NUM_STAGES + 1);

    state_t                state;
    state_t                state_n;
    logic [NUM_STAGES-1:0] done_mask;
    logic [NUM_STAGES-1:0] fail_mask;
    logic [NUM_STAGES-1:0] done_n;
    logic [NUM_STAGES-1:0] fail_n;
    logic [NUM_STAGES-1:0] live_mask;
    logic [CNT_W-1:0]      cnt;
    logic [FW-1:0]         flush_cnt;
    logic [PW-1:0]         pc;
    logic [PASSED_W-1:0]   passed_now;
    logic                  pass_q;
    logic                  is_face_q;
    logic                  timeout_q;
    logic [PASSED_W-1:0]   passed_q;
    logic                  accept;
    logic                  first_pass;
    logic                  first_fail;
    logic                  fail_now;
    logic                  all_done;
    logic                  timeout_hit;
    logic                  flush_last;

    assign accept     = (state == ST_IDLE) && bus.i_window_valid;
    assign first_pass = (state == ST_FIRST) && bus.i_first_stage_done
                        && bus.i_first_stage_pass;
    assign first_fail = (state == ST_FIRST) && bus.i_first_stage_done
                        && !bus.i_first_stage_pass;

    // Masks including this cycle's strobes, so verdicts need no extra cycle
    always_comb begin
        done_n = done_mask | (bus.i_end_database & TRACK_MASK);
        fail_n = fail_mask
               | (bus.i_end_database & bus.i_stage_fail & TRACK_MASK);
    end

    assign live_mask   = done_n & ~fail_n;
    assign fail_now    = |fail_n;
    assign all_done    = (done_n & TRACK_MASK) == TRACK_MASK;
    assign timeout_hit = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign flush_last  = flush_cnt == FW'(FLUSH_CYCLES - 1);

    popcount #(
        .W(NUM_STAGES)
    ) u_popcount (
        .bits  (live_mask),
        .count (pc)
    );

    assign passed_now = PASSED_W'(NUM_FIRST_STAGES) + PASSED_W'(pc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_INIT: begin
                if (bus.i_load_done) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) state_n = ST_FIRST;
            end
            ST_FIRST: begin
                if (first_pass) state_n = ST_LATER;
                else if (first_fail) state_n = ST_RESULT;
            end
            ST_LATER: begin
                if (fail_now || all_done || timeout_hit)
                    state_n = ST_RESULT;
            end
            ST_RESULT: begin
                state_n = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_last) state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_INIT;
            end
        endcase
    end

    always_comb begin
        bus.o_window_ready   = 1'b0;
        bus.o_enable         = 1'b0;
        bus.o_reset_database = 1'b0;
        bus.o_result_valid   = 1'b0;
        bus.o_busy           = 1'b1;
        unique case (state)
            ST_IDLE: begin
                bus.o_window_ready = 1'b1;
                bus.o_busy         = 1'b0;
            end
            ST_LATER:  bus.o_enable         = 1'b1;
            ST_RESULT: bus.o_result_valid   = 1'b1;
            ST_FLUSH:  bus.o_reset_database = 1'b1;
            default: begin
                bus.o_busy = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_mask <= '0;
            fail_mask <= '0;
            cnt       <= '0;
            flush_cnt <= '0;
            pass_q    <= 1'b0;
            is_face_q <= 1'b0;
            timeout_q <= 1'b0;
            passed_q  <= '0;
        end else begin
            pass_q <= first_pass;
            if (accept) begin
                done_mask <= '0;
                fail_mask <= '0;
                cnt       <= '0;
            end
            if (state == ST_LATER) begin
                done_mask <= done_n;
                fail_mask <= fail_n;
                cnt       <= cnt + 1'b1;
            end
            if (state == ST_RESULT) flush_cnt <= '0;
            if (state == ST_FLUSH)  flush_cnt <= flush_cnt + 1'b1;
            if (first_fail) begin
                is_face_q <= 1'b0;
                timeout_q <= 1'b0;
                passed_q  <= '0;
            end
            // Fail beats completion, completion beats timeout
            if ((state == ST_LATER) && (state_n == ST_RESULT)) begin
                is_face_q <= !fail_now && all_done;
                timeout_q <= !fail_now && !all_done;
                passed_q  <= passed_now;
            end
        end
    end

    assign bus.o_pass_first_stage = pass_q;
    assign bus.o_is_face          = is_face_q;
    assign bus.o_timeout          = timeout_q;
    assign bus.o_stages_passed    = passed_q;

endmodule

// File: tb/tb_cascade_controller.sv
// Directed self-checking bench for cascade_controller.
// Inputs change 1ns after posedge; outputs are sampled there too.
module tb_cascade_controller;
    import cascade_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   pass_pulses;

    cascade_controller_if bus();

    cascade_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.o_pass_first_stage) pass_pulses <= pass_pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.i_window_valid     = 1'b0;
        bus.i_first_stage_done = 1'b0;
        bus.i_first_stage_pass = 1'b0;
        bus.i_end_database     = '0;
        bus.i_stage_fail       = '0;
    endtask

    task automatic accept_window();
        bus.i_window_valid = 1'b1;
        tick();
        bus.i_window_valid = 1'b0;
        checks++;
        if (bus.o_window_ready !== 1'b0 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL accept: ready=%b busy=%b need 0/1",
                     bus.o_window_ready, bus.o_busy);
        end
    endtask

    task automatic enter_later();
        accept_window();
        bus.i_first_stage_done = 1'b1;
        bus.i_first_stage_pass = 1'b1;
        tick();
        bus.i_first_stage_done = 1'b0;
        bus.i_first_stage_pass = 1'b0;
        checks++;
        if (bus.o_pass_first_stage !== 1'b1 || bus.o_enable !== 1'b1) begin
            errors++;
            $display("FAIL first_pass: pass=%b enable=%b need 1/1",
                     bus.o_pass_first_stage, bus.o_enable);
        end
    endtask

    task automatic strobe_range(input int lo, input int hi);
        logic [NUM_STAGES-1:0] v;
        for (int s = lo; s <= hi; s++) begin
            v = '0;
            v[s] = 1'b1;
            bus.i_end_database = v;
            tick();
        end
        bus.i_end_database = '0;
    endtask

    task automatic check_result(input string name, input logic face,
                                input logic tmo, input int passed);
        checks++;
        if (bus.o_result_valid !== 1'b1 || bus.o_is_face !== face ||
            bus.o_timeout !== tmo ||
            bus.o_stages_passed !== PASSED_W'(passed)) begin
            errors++;
            $display("FAIL %s: valid=%b face=%b tmo=%b passed=%0d need 1/%b/%b/%0d",
                     name, bus.o_result_valid, bus.o_is_face,
                     bus.o_timeout, bus.o_stages_passed, face, tmo, passed);
        end
    endtask

    task automatic check_flush(input string name);
        int rdb = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.o_reset_database === 1'b1) rdb++;
        end
        tick();
        checks++;
        if (rdb != 2 || bus.o_reset_database !== 1'b0 ||
            bus.o_window_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_flush: rdb_cycles=%0d rdb=%b ready=%b need 2/0/1",
                     name, rdb, bus.o_reset_database, bus.o_window_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.i_load_done = 1'b0;
        drive_idle();
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_window_ready !== 1'b0 ||
            bus.o_enable !== 1'b0 || bus.o_reset_database !== 1'b0 ||
            bus.o_result_valid !== 1'b0 || bus.o_pass_first_stage !== 1'b0 ||
            bus.o_is_face !== 1'b0 || bus.o_timeout !== 1'b0 ||
            bus.o_stages_passed !== 5'd0) begin
            errors++;
            $display("FAIL reset: busy=%b ready=%b en=%b rdb=%b rv=%b face=%b tmo=%b sp=%0d",
                     bus.o_busy, bus.o_window_ready, bus.o_enable,
                     bus.o_reset_database, bus.o_result_valid,
                     bus.o_is_face, bus.o_timeout, bus.o_stages_passed);
        end
    endtask

    task automatic test_load_gating();
        int bad = 0;
        bus.i_window_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.o_window_ready !== 1'b0 || bus.o_busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL load_gating: bad_cycles=%0d need 0", bad);
        end
        bus.i_window_valid = 1'b0;
        bus.i_load_done = 1'b1;
        tick();
        checks++;
        if (bus.o_window_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL load_done: ready=%b busy=%b need 1/0",
                     bus.o_window_ready, bus.o_busy);
        end
    endtask

    task automatic test_first_reject();
        accept_window();
        bus.i_first_stage_done = 1'b1;
        bus.i_first_stage_pass = 1'b0;
        tick();
        bus.i_first_stage_done = 1'b0;
        check_result("first_reject", 1'b0, 1'b0, 0);
        checks++;
        if (bus.o_enable !== 1'b0) begin
            errors++;
            $display("FAIL reject_enable: enable=%b need 0", bus.o_enable);
        end
        check_flush("reject");
    endtask

    task automatic test_full_pass();
        pass_pulses = 0;
        enter_later();
        strobe_range(3, 24);
        check_result("full_pass", 1'b1, 1'b0, 25);
        check_flush("full");
        checks++;
        if (pass_pulses != 1) begin
            errors++;
            $display("FAIL pass_pulses: got %0d need 1", pass_pulses);
        end
        checks++;
        if (bus.o_is_face !== 1'b1 || bus.o_stages_passed !== 5'd25) begin
            errors++;
            $display("FAIL hold: face=%b sp=%0d need 1/25",
                     bus.o_is_face, bus.o_stages_passed);
        end
    endtask

    task automatic test_mid_fail();
        enter_later();
        strobe_range(3, 9);
        bus.i_end_database = (25'd1 << 10) | (25'd1 << 11);
        bus.i_stage_fail   = 25'd1 << 10;
        tick();
        bus.i_end_database = '0;
        bus.i_stage_fail   = '0;
        check_result("mid_fail", 1'b0, 1'b0, 11);
        check_flush("mid");
    endtask

    task automatic test_first_bits_ignored();
        enter_later();
        bus.i_end_database = 25'h7;
        bus.i_stage_fail   = 25'h7;
        tick();
        bus.i_stage_fail = '0;
        checks++;
        if (bus.o_enable !== 1'b1 || bus.o_result_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_bits: enable=%b rv=%b need 1/0",
                     bus.o_enable, bus.o_result_valid);
        end
        bus.i_end_database = 25'h1FF_FFF8;
        tick();
        bus.i_end_database = '0;
        check_result("all_at_once", 1'b1, 1'b0, 25);
        check_flush("bulk");
    endtask

    task automatic test_timeout();
        int n = 0;
        enter_later();
        while (bus.o_result_valid !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        checks++;
        if (n != 4095) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles need 4095", n);
        end
        check_result("timeout", 1'b0, 1'b1, 3);
        check_flush("timeout");
    endtask

    task automatic test_reset_mid();
        int rv = 0;
        enter_later();
        strobe_range(3, 7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_window_ready !== 1'b0 ||
            bus.o_enable !== 1'b0 || bus.o_result_valid !== 1'b0 ||
            bus.o_timeout !== 1'b0 || bus.o_stages_passed !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b ready=%b en=%b rv=%b tmo=%b sp=%0d",
                     bus.o_busy, bus.o_window_ready, bus.o_enable,
                     bus.o_result_valid, bus.o_timeout, bus.o_stages_passed);
        end
        for (int i = 0; i < 3; i++) begin
            if (bus.o_result_valid === 1'b1) rv++;
            if (i < 2) tick();
        end
        checks++;
        if (rv != 0 || bus.o_window_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_idle: rv=%0d ready=%b need 0/1",
                     rv, bus.o_window_ready);
        end
        enter_later();
        strobe_range(3, 24);
        check_result("after_reset", 1'b1, 1'b0, 25);
        check_flush("after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_gating();
        test_first_reject();
        test_full_pass();
        test_mid_fail();
        test_first_bits_ignored();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
